led_afterglow_fader: RTL and testbench

- Output stage directly downstream of the Knight Rider LED shift register.
- Consumes the one-hot LED position vector and gives each LED a decaying intensity, producing the classic fading tail.
- Drives each pad with a PWM waveform; a global brightness level is stepped by a pre-synchronised, edge-detected button pulse.
- Runs on the same single system clock as the shift register.

---
 rtl/led_afterglow_fader.sv | 132 +++++++++++++
 tb/tb_led_afterglow_fader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_afterglow_fader.sv
// -----------------------------------------------------------------------------
// led_afterglow_fader
//
// Output stage for the Knight Rider LED shift register. Each LED channel keeps
// a 3-bit intensity that jumps to full whenever its position bit is set and
// (optionally) decays one step every DECAY_DIV cycles, giving the fading tail.
// The intensity is scaled by a global 2-bit brightness level and turned into a
// registered 8-slot PWM waveform per pad.
//
// Build option:
//   FADER_TAIL_EN  defined   -> afterglow decay (prescaler + per-channel
//                               countdown) is built.
//                  undefined -> intensity is simply 7 while led_in is high and
//                               0 otherwise; DECAY_DIV has no effect.
//
// Parameters:
//   N_LEDS     number of LED channels (width of led_in / pwm_out)
//   DECAY_DIV  clock cycles per intensity decay step, 2..16383
//
// Ports:
//   clk              system clock, rising-edge active
//   reset            synchronous active-high reset
//   led_in           LED position vector (normally one-hot, any pattern legal)
//   brightness_step  single-cycle pulse, advances brightness 3->0->1->2->3
//   pwm_out          registered PWM drive, one bit per LED
//   bright_level     current global brightness level (3 = full)
// -----------------------------------------------------------------------------
module led_afterglow_fader #(
    parameter int N_LEDS    = 8,
    parameter int DECAY_DIV = 750
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_LEDS-1:0] led_in,
    input  logic              brightness_step,
    output logic [N_LEDS-1:0] pwm_out,
    output logic [1:0]        bright_level
);

    // The prescaler is 14 bits wide, so the divider must fit in it.
    if (DECAY_DIV < 2 || DECAY_DIV > 16383) begin : g_bad_decay_div
        $error("DECAY_DIV must lie in 2..16383");
    end

    logic [2:0] r_pwm_cnt;
    logic [1:0] r_bright_level;
    logic [2:0] w_level_p1;

    // Free-running PWM slot counter; one 8-cycle window per wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= 3'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 3'd1;
        end
    end

    // Global brightness, wraps 3 -> 0. Reset has priority over a step pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bright_level <= 2'd3;
        end else if (brightness_step) begin
            r_bright_level <= r_bright_level + 2'd1;
        end
    end

    assign bright_level = r_bright_level;

    // Scale factor is level+1 (1..4); needs 3 bits to hold 4.
    assign w_level_p1 = {1'b0, r_bright_level} + 3'd1;

`ifdef FADER_TAIL_EN
    localparam logic [13:0] PRESC_LAST = 14'(DECAY_DIV - 1);

    logic [13:0] r_presc;
    logic        w_decay_tick;

    assign w_decay_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= 14'd0;
        end else if (w_decay_tick) begin
            r_presc <= 14'd0;
        end else begin
            r_presc <= r_presc + 14'd1;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi = gi + 1) begin : g_ch
            logic [2:0] r_inten;
            logic [2:0] w_eff;
            logic       r_pwm;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_inten <= 3'd0;
`ifdef FADER_TAIL_EN
                // A fresh position bit always beats a coincident decay tick.
                end else if (led_in[gi]) begin
                    r_inten <= 3'd7;
                end else if (w_decay_tick && (r_inten != 3'd0)) begin
                    r_inten <= r_inten - 3'd1;
                end
`else
                end else begin
                    r_inten <= led_in[gi] ? 3'd7 : 3'd0;
                end
`endif
            end

            // (inten * (level+1)) >> 2, truncated. Max product 28 fits in
            // the 6-bit operands, so nothing is lost before the shift.
            assign w_eff = 3'(({3'b000, r_inten} * {3'b000, w_level_p1}) >> 2);

            // eff==7 is forced to full duty; otherwise eff slots out of 8.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pwm <= 1'b0;
                end else begin
                    r_pwm <= (w_eff == 3'd7) | (r_pwm_cnt < w_eff);
                end
            end

            assign pwm_out[gi] = r_pwm;
        end
    endgenerate

endmodule

// File: tb/tb_led_afterglow_fader.sv
// -----------------------------------------------------------------------------
// tb_led_afterglow_fader
//
// Self-checking bench. A cycle model predicts pwm_out / bright_level from the
// stimulus applied before each edge; the prediction is queued and compared
// just after the edge. Directed phases add window high-count checks against
// fixed expected values. Decay-specific phases are built only with
// FADER_TAIL_EN defined.
// -----------------------------------------------------------------------------
module tb_led_afterglow_fader;

    localparam int N   = 8;
    localparam int DIV = 64;
`ifdef FADER_TAIL_EN
    localparam bit TAIL = 1'b1;
`else
    localparam bit TAIL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] led_in = '0;
    logic         brightness_step = 1'b0;
    logic [N-1:0] pwm_out;
    logic [1:0]   bright_level;

    always #5 clk = ~clk;

    led_afterglow_fader #(
        .N_LEDS   (N),
        .DECAY_DIV(DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .led_in         (led_in),
        .brightness_step(brightness_step),
        .pwm_out        (pwm_out),
        .bright_level   (bright_level)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [N-1:0] pwm;
        logic [1:0]   lvl;
    } exp_t;

    exp_t   exp_q[$];
    int     m_cnt   = 0;
    int     m_presc = 0;
    int     m_lvl   = 3;
    int     m_inten[N];
    logic [N-1:0] m_pwm = '0;

    function automatic int eff_of(input int inten, input int lvl);
        return (inten * (lvl + 1)) / 4;
    endfunction

    task automatic model_step();
        int e;
        bit dtick;
        if (reset) begin
            m_cnt   = 0;
            m_presc = 0;
            m_lvl   = 3;
            m_pwm   = '0;
            for (int i = 0; i < N; i++) m_inten[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                e = eff_of(m_inten[i], m_lvl);
                m_pwm[i] = (e == 7) || (m_cnt < e);
            end
            dtick = TAIL && (m_presc == DIV - 1);
            for (int i = 0; i < N; i++) begin
                if (led_in[i])               m_inten[i] = 7;
                else if (!TAIL)              m_inten[i] = 0;
                else if (dtick && m_inten[i] > 0) m_inten[i] = m_inten[i] - 1;
            end
            m_presc = dtick ? 0 : m_presc + 1;
            m_cnt   = (m_cnt + 1) % 8;
            if (brightness_step) m_lvl = (m_lvl + 1) % 4;
        end
    endtask

    // One clock: predict, push, advance, pop and compare.
    task automatic tick();
        exp_t e;
        model_step();
        exp_q.push_back({m_pwm, 2'(m_lvl)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("pwm_out", 32'(pwm_out), 32'(e.pwm));
        check_eq("bright_level", 32'(bright_level), 32'(e.lvl));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int win_hi[N];

    task automatic window(input string name);
        for (int i = 0; i < N; i++) win_hi[i] = 0;
        repeat (8) begin
            tick();
            for (int i = 0; i < N; i++) win_hi[i] += int'(pwm_out[i]);
        end
        $display("window %s: hi0=%0d hi1=%0d hi2=%0d hi3=%0d lvl=%0d",
                 name, win_hi[0], win_hi[1], win_hi[2], win_hi[3], bright_level);
    endtask

    task automatic align();
        while (m_cnt != 0) tick();
    endtask

    // Watchdog: the run is a fixed number of cycles, this only guards a hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lvl_exp[4];
        int cnt_exp[4];
        int decay_exp[9];
        int acc;
        lvl_exp   = '{0, 1, 2, 3};
        cnt_exp   = '{1, 3, 5, 8};
        decay_exp = '{8, 6, 5, 4, 3, 2, 1, 0, 0};

        // ---- reset held with everything asserted ----
        reset = 1'b1; led_in = 8'hFF; brightness_step = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_pwm", 32'(pwm_out), 32'h00);
            check_eq("rst_lvl", 32'(bright_level), 32'd3);
        end
        $display("reset phase done");
        reset = 1'b0; brightness_step = 1'b0; led_in = 8'h01;
        tick();
        for (int c = 0; c < 16; c++) begin
            tick();
            check_eq("post_rst_pwm", 32'(pwm_out), 32'h01);
        end
        $display("post-reset hold done");

        // ---- brightness stepping with led_in[0] held ----
        align();
        window("bright_l3");
        check_eq("bright_win_init", 32'(win_hi[0]), 32'd8);
        for (int p = 0; p < 4; p++) begin
            brightness_step = 1'b1;
            tick();
            brightness_step = 1'b0;
            run(23);
            window("bright_step");
            check_eq("bright_lvl", 32'(bright_level), 32'(lvl_exp[p]));
            check_eq("bright_win", 32'(win_hi[0]), 32'(cnt_exp[p]));
        end
        led_in = 8'h00;

`ifndef FADER_TAIL_EN
        // ---- no tail: pwm_out follows led_in two cycles later ----
        reset = 1'b1; tick(); reset = 1'b0;
        led_in = 8'h01; tick();
        led_in = 8'h02; tick();
        check_eq("seq_e2", 32'(pwm_out), 32'h01);
        led_in = 8'h04; tick();
        check_eq("seq_e3", 32'(pwm_out), 32'h02);
        led_in = 8'h00; tick();
        check_eq("seq_e4", 32'(pwm_out), 32'h04);
        tick();
        check_eq("seq_e5", 32'(pwm_out), 32'h00);
        tick();
        check_eq("seq_e6", 32'(pwm_out), 32'h00);
        $display("no-tail sequence done");
`else
        // ---- decay tail from a single-cycle pulse ----
        reset = 1'b1; tick(); reset = 1'b0;
        led_in = 8'h01; tick(); led_in = 8'h00;
        run(7);
        for (int w = 1; w < 72; w++) begin
            window("decay");
            if (w % 8 == 7) check_eq("decay_win", 32'(win_hi[0]), 32'(decay_exp[w / 8]));
        end

        // ---- led_in coincident with a decay tick ----
        reset = 1'b1; tick(); reset = 1'b0;
        led_in = 8'h08; tick(); led_in = 8'h00;
        run(247);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) led_in = 8'h08;
            tick();
            led_in = 8'h00;
            acc += int'(pwm_out[3]);
        end
        $display("window simul_pre: hi3=%0d", acc);
        check_eq("simul_pre", 32'(acc), 32'd4);
        window("simul_post");
        check_eq("simul_post", 32'(win_hi[3]), 32'd8);
        run(48);
        window("simul_hold");
        check_eq("simul_hold", 32'(win_hi[3]), 32'd8);
        window("simul_next");
        check_eq("simul_next", 32'(win_hi[3]), 32'd6);

        // ---- reset in the middle of a tail ----
        reset = 1'b1; tick(); reset = 1'b0;
        led_in = 8'h01; tick(); led_in = 8'h00; run(127);
        led_in = 8'h02; tick(); led_in = 8'h00; run(127);
        led_in = 8'h04; tick(); led_in = 8'h00; run(127);
        window("mid_pre");
        check_eq("mid_pre_b0", 32'(win_hi[0]), 32'd1);
        check_eq("mid_pre_b1", 32'(win_hi[1]), 32'd3);
        check_eq("mid_pre_b2", 32'(win_hi[2]), 32'd5);
        brightness_step = 1'b1; tick(); brightness_step = 1'b0;
        run(7);
        reset = 1'b1; tick();
        check_eq("mid_rst_pwm", 32'(pwm_out), 32'h00);
        check_eq("mid_rst_lvl", 32'(bright_level), 32'd3);
        reset = 1'b0;
        led_in = 8'h01; tick(); led_in = 8'h00;
        run(55);
        window("mid_restart_a");
        check_eq("mid_restart_a", 32'(win_hi[0]), 32'd8);
        window("mid_restart_b");
        check_eq("mid_restart_b", 32'(win_hi[0]), 32'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
